// File: rtl/wishbone_uart_host_bridge.sv
// wishbone_uart_host_bridge: Wishbone slave that sends each access as a 4-byte UART command
// and completes the bus cycle from the chip's 1-byte reply.
module wishbone_uart_host_bridge #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [22:0] adr_i,
    input  logic [7:0]  dat_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [7:0]  dat_o,
    output logic        uart_txd,
    input  logic        uart_rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [31:0]   cmd_q, cmd_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    dat_q, dat_d;
    logic          fail_q, fail_d;
    logic          abort_q, abort_d;
    logic [1:0]    sync_q, sync_d;
    logic          rxd_s, req, bit_end;
    logic [7:0]    tx_byte;

    assign rxd_s   = sync_q[1];
    assign req     = cyc_i & stb_i;
    assign bit_end = clk_cnt_q == BIT_LAST;
    assign tx_byte = byte_cnt_q == 2'd0 ? cmd_q[31:24] :
                     byte_cnt_q == 2'd1 ? cmd_q[23:16] :
                     byte_cnt_q == 2'd2 ? cmd_q[15:8]  : cmd_q[7:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            cmd_q      <= '0;
            rx_sh_q    <= '0;
            dat_q      <= '0;
            fail_q     <= 1'b0;
            abort_q    <= 1'b0;
            sync_q     <= 2'b11;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            cmd_q      <= cmd_d;
            rx_sh_q    <= rx_sh_d;
            dat_q      <= dat_d;
            fail_q     <= fail_d;
            abort_q    <= abort_d;
            sync_q     <= sync_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        cmd_d      = cmd_q;
        rx_sh_d    = rx_sh_q;
        dat_d      = dat_q;
        fail_d     = fail_q;
        // once the master lets go, the frame still completes but its termination is swallowed
        abort_d    = abort_q | ~req;
        sync_d     = {sync_q[0], uart_rxd};
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (req) begin
                    state_d    = TX_START;
                    cmd_d      = {we_i, adr_i, dat_i};
                    byte_cnt_d = '0;
                    fail_d     = 1'b0;
                    abort_d    = 1'b0;
                end
            end
            TX_START: if (bit_end) begin
                state_d   = TX_DATA;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
            TX_DATA: if (bit_end) begin
                clk_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + 3'd1;
                state_d   = bit_cnt_q == 3'd7 ? TX_STOP : TX_DATA;
            end
            TX_STOP: if (bit_end) begin
                clk_cnt_d  = '0;
                byte_cnt_d = byte_cnt_q + 2'd1;
                to_cnt_d   = '0;
                state_d    = byte_cnt_q == 2'd3 ? RX_WAIT : TX_START;
            end
            RX_WAIT: begin
                clk_cnt_d = '0;
                to_cnt_d  = to_cnt_q + TW'(1);
                if (!rxd_s) begin
                    state_d = RX_START;
                end else if (to_cnt_q >= TO_LAST) begin
                    state_d = DONE;
                    fail_d  = 1'b1;
                end
            end
            // a start bit that is gone by mid-bit was a glitch; the timeout keeps running
            RX_START: if (clk_cnt_q == BIT_HALF) begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = rxd_s ? RX_WAIT : RX_DATA;
            end
            RX_DATA: if (bit_end) begin
                clk_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_sh_d   = {rxd_s, rx_sh_q[7:1]};
                state_d   = bit_cnt_q == 3'd7 ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (bit_end) begin
                state_d = DONE;
                fail_d  = ~rxd_s;
                dat_d   = rxd_s && !cmd_q[31] ? rx_sh_q : dat_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uart_txd = state_q == TX_START ? 1'b0 : state_q == TX_DATA ? tx_byte[bit_cnt_q] : 1'b1;
        ack_o    = state_q == DONE && req && !abort_q && !fail_q;
        err_o    = state_q == DONE && req && !abort_q && fail_q;
        dat_o    = dat_q;
    end
endmodule
